// File: rtl/siso_frame_if.sv
`default_nettype none
// ============================================================================
// Module      : siso_frame_if
// Description : Handshake and serial-register signals of the SISO frame
//               controller, with controller (master) and environment (slave)
//               views.
// Revision    : 1.0 - initial release
// ============================================================================
interface siso_frame_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sr_din;
    logic             sr_en;
    logic             sr_dout;
    logic             out_bit;
    logic             out_bit_valid;
    logic             out_last;
    logic             busy;

    modport master (
        input  in_data, in_valid, sr_dout,
        output in_ready, sr_din, sr_en, out_bit, out_bit_valid, out_last, busy
    );

    modport slave (
        output in_data, in_valid, sr_dout,
        input  in_ready, sr_din, sr_en, out_bit, out_bit_valid, out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/siso_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : siso_frame_ctrl
// Description : Serializes an accepted parallel word into an external SISO
//               shift register, flushes it through, and tags emerging bits.
// Revision    : 1.0 - initial release
// ============================================================================
module siso_frame_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         clr,
    siso_frame_if.master bus
);

    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] r_emerged;
    logic [WIDTH-1:0]   r_shadow;
    logic [DEPTH-1:0]   r_tag;
    logic               r_sr_din;
    logic               r_sr_en;
    logic               r_out_last;
    logic               r_in_ready;

    logic               w_accept;
    logic               w_tag_in;
    logic [DEPTH-1:0]   w_tag_shifted;
    logic               w_tag_top_next;
    logic               w_frame_last;
    logic               w_first_bit;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [c_CNT_W-1:0] w_idx_next;

    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_first_bit = (LSB_FIRST != 0) ? bus.in_data[0] : bus.in_data[WIDTH-1];
    assign w_cnt_next  = r_cnt + c_CNT_ONE;
    assign w_idx_next  = (LSB_FIRST != 0) ? w_cnt_next : (c_CNT_LAST - w_cnt_next);

    // Tag chain mirrors the external register: 1 marks a frame bit, 0 a flush bit.
    assign w_tag_in = (r_state == c_ST_SHIFT);

    generate
        if (DEPTH == 1) begin : g_tag_single
            assign w_tag_shifted = w_tag_in;
        end else begin : g_tag_chain
            assign w_tag_shifted = {r_tag[DEPTH-2:0], w_tag_in};
        end
    endgenerate

    assign w_tag_top_next = w_tag_shifted[DEPTH-1];
    assign w_frame_last   = w_tag_top_next && (r_emerged == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_emerged  <= '0;
            r_shadow   <= '0;
            r_tag      <= '0;
            r_sr_din   <= 1'b0;
            r_sr_en    <= 1'b0;
            r_out_last <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            // Tags and the last-bit marker advance only with enabled shifts.
            if (r_sr_en) begin
                r_tag      <= w_tag_shifted;
                r_out_last <= w_frame_last;
                if (w_tag_top_next) begin
                    r_emerged <= w_frame_last ? '0 : (r_emerged + c_CNT_ONE);
                end
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_shadow   <= bus.in_data;
                        r_cnt      <= '0;
                        r_emerged  <= '0;
                        r_sr_din   <= w_first_bit;
                        r_sr_en    <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt    <= '0;
                        r_sr_din <= 1'b0;
                        if (r_out_last) begin
                            r_sr_en    <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_state    <= c_ST_IDLE;
                        end else begin
                            r_state <= c_ST_FLUSH;
                        end
                    end else begin
                        r_cnt    <= w_cnt_next;
                        r_sr_din <= r_shadow[w_idx_next];
                    end
                end
                c_ST_FLUSH: begin
                    // The edge that ends the out_last cycle is the final shift.
                    if (r_out_last) begin
                        r_sr_en    <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_sr_din   <= 1'b0;
                    r_sr_en    <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.busy          = ~r_in_ready;
    assign bus.sr_din        = r_sr_din;
    assign bus.sr_en         = r_sr_en;
    assign bus.out_bit       = bus.sr_dout;
    assign bus.out_bit_valid = r_tag[DEPTH-1];
    assign bus.out_last      = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_siso_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_siso_frame_ctrl
// Description : Drives three controller configurations against SISO register
//               models and a cycle-scheduled reference of expected frame bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_siso_frame_ctrl;

    localparam int NC = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr  = 1'b0;
    int         cyc  = 0;
    logic [7:0] din8 = '0;
    logic       vld8 = 1'b0;
    logic [1:0] din2 = '0;
    logic       vld2 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    siso_frame_if #(.WIDTH(8)) bus_a ();
    siso_frame_if #(.WIDTH(8)) bus_b ();
    siso_frame_if #(.WIDTH(2)) bus_c ();

    assign bus_a.in_data  = din8;
    assign bus_a.in_valid = vld8;
    assign bus_b.in_data  = din8;
    assign bus_b.in_valid = vld8;
    assign bus_c.in_data  = din2;
    assign bus_c.in_valid = vld2;

    // External SISO registers, preloaded with 1s.
    logic [3:0] sr_a = 4'hF;
    logic [3:0] sr_b = 4'hF;
    logic       sr_c = 1'b1;
    always @(posedge clk) begin
        if (bus_a.sr_en) sr_a <= {sr_a[2:0], bus_a.sr_din};
        if (bus_b.sr_en) sr_b <= {sr_b[2:0], bus_b.sr_din};
        if (bus_c.sr_en) sr_c <= bus_c.sr_din;
    end
    assign bus_a.sr_dout = sr_a[3];
    assign bus_b.sr_dout = sr_b[3];
    assign bus_c.sr_dout = sr_c;

    siso_frame_ctrl #(.WIDTH(8), .DEPTH(4), .LSB_FIRST(1)) u_dut_a (.clk(clk), .clr(clr), .bus(bus_a));
    siso_frame_ctrl #(.WIDTH(8), .DEPTH(4), .LSB_FIRST(0)) u_dut_b (.clk(clk), .clr(clr), .bus(bus_b));
    siso_frame_ctrl #(.WIDTH(2), .DEPTH(1), .LSB_FIRST(1)) u_dut_c (.clk(clk), .clr(clr), .bus(bus_c));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", tag, cyc, act, exp);
        end
    endtask

    // Reference: per-cycle schedule of expected outputs. Model 0 covers the
    // 8x4 configurations (erev holds the MSB-first order), model 1 the 2x1.
    bit ev    [2][NC];
    bit ebit  [2][NC];
    bit elast [2][NC];
    bit een   [2][NC];
    bit erev  [NC];
    int nf    [2];
    bit known = 1'b0;

    initial begin
        nf[0] = 0;
        nf[1] = 0;
    end

    task automatic accept(input int m, input logic [7:0] w, input int wd, input int d, input int a);
        for (int k = 0; k < wd; k++) begin
            ev[m][a+d+1+k]    = 1'b1;
            ebit[m][a+d+1+k]  = w[k];
            elast[m][a+d+1+k] = (k == wd - 1);
            if (m == 0) erev[a+d+1+k] = w[wd-1-k];
        end
        for (int c = a + 1; c <= a + d + wd; c++) een[m][c] = 1'b1;
        nf[m] = a + d + wd + 1;
    endtask

    always @(negedge clk) begin
        if (known) begin
            check_eq("a_ready", bus_a.in_ready, cyc >= nf[0]);
            check_eq("a_busy",  bus_a.busy,     cyc <  nf[0]);
            check_eq("a_sr_en", bus_a.sr_en,    een[0][cyc]);
            check_eq("a_valid", bus_a.out_bit_valid, ev[0][cyc]);
            check_eq("a_last",  bus_a.out_last, elast[0][cyc]);
            if (ev[0][cyc]) check_eq("a_bit", bus_a.out_bit, ebit[0][cyc]);

            check_eq("b_ready", bus_b.in_ready, cyc >= nf[0]);
            check_eq("b_valid", bus_b.out_bit_valid, ev[0][cyc]);
            check_eq("b_last",  bus_b.out_last, elast[0][cyc]);
            if (ev[0][cyc]) check_eq("b_bit", bus_b.out_bit, erev[cyc]);

            check_eq("c_ready", bus_c.in_ready, cyc >= nf[1]);
            check_eq("c_sr_en", bus_c.sr_en,    een[1][cyc]);
            check_eq("c_valid", bus_c.out_bit_valid, ev[1][cyc]);
            check_eq("c_last",  bus_c.out_last, elast[1][cyc]);
            if (ev[1][cyc]) check_eq("c_bit", bus_c.out_bit, ebit[1][cyc]);
        end

        if (!clr) begin
            known = 1'b1;
            for (int i = cyc + 1; i <= cyc + 16 && i < NC; i++) begin
                for (int m = 0; m < 2; m++) begin
                    ev[m][i]    = 1'b0;
                    ebit[m][i]  = 1'b0;
                    elast[m][i] = 1'b0;
                    een[m][i]   = 1'b0;
                end
                erev[i] = 1'b0;
            end
            nf[0] = cyc + 1;
            nf[1] = cyc + 1;
        end else if (known) begin
            if (vld8 && cyc >= nf[0]) accept(0, din8, 8, 4, cyc);
            if (vld2 && cyc >= nf[1]) accept(1, {6'b0, din2}, 2, 1, cyc);
        end
    end

    // Called just after a rising edge; returns once model m expects idle.
    task automatic wait_idle(input int m);
        for (int i = 0; i < 64 && cyc < nf[m]; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send8(input logic [7:0] w);
        wait_idle(0);
        din8 = w;
        vld8 = 1'b1;
        @(posedge clk);
        #1;
        vld8 = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;

        // 2x1 configuration, word 2'b10.
        wait_idle(1);
        din2 = 2'b10;
        vld2 = 1'b1;
        @(posedge clk);
        #1;
        vld2 = 1'b0;

        send8(8'hA5);
        din8 = 8'h3C;
        send8(8'h81);
        din8 = 8'h7E;

        // Back-to-back: 8'hFF then 8'h00 with in_valid held high.
        wait_idle(0);
        din8 = 8'hFF;
        vld8 = 1'b1;
        @(posedge clk);
        #1;
        din8 = 8'h00;
        wait_idle(0);
        @(posedge clk);
        #1;
        vld8 = 1'b0;

        // Reset during SHIFT in cycle A+3, then a clean frame.
        wait_idle(0);
        din8 = 8'hC3;
        vld8 = 1'b1;
        @(posedge clk);
        #1;
        vld8 = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        send8(8'h5A);

        for (int r = 0; r < 900; r++) begin
            @(posedge clk);
            #1;
            clr  = ($urandom_range(0, 149) != 0);
            vld8 = ($urandom_range(0, 3) == 0);
            din8 = 8'($urandom);
            vld2 = ($urandom_range(0, 2) == 0);
            din2 = 2'($urandom);
        end
        clr  = 1'b1;
        vld8 = 1'b0;
        vld2 = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
